// File: rtl/paddle_pos_if.sv
// Handshake bundle between the paddle controller and its neighbours:
// step/tick/recenter pulses in, registered position and status out.
interface paddle_pos_if #(
    parameter int POS_W = 10
);
    logic             left_op;
    logic             right_op;
    logic             frame_tick;
    logic             recenter;
    logic [POS_W-1:0] pos;
    logic             moving;
    logic             at_min;
    logic             at_max;
    logic             overflow;

    modport master (
        output left_op, right_op, frame_tick, recenter,
        input  pos, moving, at_min, at_max, overflow
    );

    modport slave (
        input  left_op, right_op, frame_tick, recenter,
        output pos, moving, at_min, at_max, overflow
    );
endinterface

// File: rtl/paddle_pos_ctrl.sv
// Paddle position controller: queues step pulses, applies one clamped step per
// frame tick, flushes the queue at the playfield limits, and walks back to centre.
module paddle_pos_ctrl #(
    parameter int POS_W    = 10,
    parameter int POS_MAX  = 400,
    parameter int STEP     = 4,
    parameter int PEND_MAX = 7,
    parameter int INIT_POS = 200
) (
    input logic         clk,
    input logic         rst_n,
    paddle_pos_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MOVING, CENTER} state_t;

    localparam logic [POS_W:0]        STEP_X = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]        MAX_X  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]        INIT_X = (POS_W+1)'(INIT_POS);
    localparam logic [POS_W-1:0]      MAX_P  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]      INIT_P = POS_W'(INIT_POS);
    localparam logic signed [4:0]     LIM    = 5'(PEND_MAX);

    state_t                state;
    logic signed [3:0]     pend;
    logic [POS_W-1:0]      pos_q;
    logic                  moving_q;
    logic                  ovf_q;

    state_t                state_nx;
    logic signed [3:0]     pend_nx;
    logic [POS_W:0]        pos_nx;
    logic                  ovf_nx;
    logic signed [4:0]     delta;
    logic signed [4:0]     pend_ext;
    logic signed [4:0]     pend_dec;
    logic signed [4:0]     sum;
    logic                  flush;

    function automatic logic signed [3:0] sat_pend(input logic signed [4:0] v);
        if (v > LIM)
            return 4'(LIM);
        else if (v < -LIM)
            return 4'(-LIM);
        else
            return 4'(v);
    endfunction

    // The POS_W+1 bit width keeps p + STEP from wrapping before the clamp.
    function automatic logic [POS_W:0] step_up(input logic [POS_W:0] p, input logic [POS_W:0] lim);
        logic [POS_W:0] s;
        s = p + STEP_X;
        return (s > lim) ? lim : s;
    endfunction

    function automatic logic [POS_W:0] step_down(input logic [POS_W:0] p, input logic [POS_W:0] lim);
        return (p < lim + STEP_X) ? lim : p - STEP_X;
    endfunction

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        pos_nx   = {1'b0, pos_q};
        ovf_nx   = 1'b0;
        flush    = 1'b0;
        pend_ext = {pend[3], pend};
        pend_dec = pend_ext;
        sum      = 5'sd0;
        delta    = 5'sd0;
        if (bus.right_op && !bus.left_op)
            delta = 5'sd1;
        else if (bus.left_op && !bus.right_op)
            delta = -5'sd1;

        if (bus.recenter && state != CENTER) begin
            state_nx = CENTER;
            pend_nx  = 4'sd0;
        end else if (state == CENTER) begin
            if (bus.frame_tick) begin
                if ({1'b0, pos_q} < INIT_X)
                    pos_nx = step_up({1'b0, pos_q}, INIT_X);
                else
                    pos_nx = step_down({1'b0, pos_q}, INIT_X);
                if (pos_nx == INIT_X)
                    state_nx = IDLE;
            end
        end else begin
            if (bus.frame_tick && pend > 4'sd0) begin
                pos_nx   = step_up({1'b0, pos_q}, MAX_X);
                pend_dec = pend_ext - 5'sd1;
                flush    = (pos_nx == MAX_X);
            end else if (bus.frame_tick && pend < 4'sd0) begin
                pos_nx   = step_down({1'b0, pos_q}, '0);
                pend_dec = pend_ext + 5'sd1;
                flush    = (pos_nx == '0);
            end
            // Reaching a wall discards whatever was still queued.
            sum      = (flush ? 5'sd0 : pend_dec) + delta;
            ovf_nx   = (sum > LIM) || (sum < -LIM);
            pend_nx  = sat_pend(sum);
            state_nx = (pend_nx != 4'sd0) ? MOVING : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 4'sd0;
            pos_q    <= INIT_P;
            moving_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            pend     <= pend_nx;
            pos_q    <= pos_nx[POS_W-1:0];
            moving_q <= (state_nx != IDLE);
            ovf_q    <= ovf_nx;
        end
    end

    assign bus.pos      = pos_q;
    assign bus.moving   = moving_q;
    assign bus.overflow = ovf_q;
    assign bus.at_min   = (pos_q == '0);
    assign bus.at_max   = (pos_q == MAX_P);
endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Scoreboard bench for paddle_pos_ctrl: directed scenarios plus biased random
// traffic, checked against a behavioural model of the paddle rules.
module tb_paddle_pos_ctrl;
    localparam int POS_W    = 10;
    localparam int POS_MAX  = 400;
    localparam int STEP     = 4;
    localparam int PEND_MAX = 7;
    localparam int INIT_POS = 200;

    typedef struct {
        int pos;
        bit moving;
        bit at_min;
        bit at_max;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    int m_pos;
    int m_pend;
    bit m_center;

    paddle_pos_if #(.POS_W(POS_W)) bus ();

    paddle_pos_ctrl #(
        .POS_W(POS_W), .POS_MAX(POS_MAX), .STEP(STEP),
        .PEND_MAX(PEND_MAX), .INIT_POS(INIT_POS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pos = INIT_POS;
        m_pend = 0;
        m_center = 1'b0;
    endfunction

    // One cycle of the paddle rules, written directly from the behaviour description.
    function automatic exp_t model_step(input bit l, input bit r, input bit t, input bit c);
        exp_t e;
        bit   ovf = 1'b0;
        bit   hit = 1'b0;
        int   s;
        if (c && !m_center) begin
            m_center = 1'b1;
            m_pend = 0;
        end else if (m_center) begin
            if (t) begin
                if (m_pos < INIT_POS) m_pos = (m_pos + STEP > INIT_POS) ? INIT_POS : m_pos + STEP;
                else if (m_pos > INIT_POS) m_pos = (m_pos - STEP < INIT_POS) ? INIT_POS : m_pos - STEP;
                if (m_pos == INIT_POS) m_center = 1'b0;
            end
        end else begin
            if (t && m_pend > 0) begin
                m_pos = (m_pos + STEP > POS_MAX) ? POS_MAX : m_pos + STEP;
                hit = (m_pos == POS_MAX);
                m_pend--;
            end else if (t && m_pend < 0) begin
                m_pos = (m_pos - STEP < 0) ? 0 : m_pos - STEP;
                hit = (m_pos == 0);
                m_pend++;
            end
            if (hit) m_pend = 0;
            s = m_pend + int'(r) - int'(l);
            if (s > PEND_MAX) begin s = PEND_MAX; ovf = 1'b1; end
            if (s < -PEND_MAX) begin s = -PEND_MAX; ovf = 1'b1; end
            m_pend = s;
        end
        e.pos = m_pos;
        e.moving = m_center || (m_pend != 0);
        e.at_min = (m_pos == 0);
        e.at_max = (m_pos == POS_MAX);
        e.ovf = ovf;
        return e;
    endfunction

    task automatic cyc(input bit l, input bit r, input bit t, input bit c);
        @(negedge clk);
        bus.left_op = l;
        bus.right_op = r;
        bus.frame_tick = t;
        bus.recenter = c;
        sb.push_back(model_step(l, r, t, c));
    endtask

    task automatic settle();
        @(negedge clk);
        bus.left_op = 1'b0;
        bus.right_op = 1'b0;
        bus.frame_tick = 1'b0;
        bus.recenter = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.left_op = 1'b0;
        bus.right_op = 1'b0;
        bus.frame_tick = 1'b0;
        bus.recenter = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every clock the DUT presents a new output set; compare it to the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pos", int'(bus.pos), e.pos);
                chk("sb_moving", int'(bus.moving), int'(e.moving));
                chk("sb_at_min", int'(bus.at_min), int'(e.at_min));
                chk("sb_at_max", int'(bus.at_max), int'(e.at_max));
                chk("sb_overflow", int'(bus.overflow), int'(e.ovf));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ovf_cnt;
        bus.left_op = 1'b0;
        bus.right_op = 1'b0;
        bus.frame_tick = 1'b0;
        bus.recenter = 1'b0;
        model_reset();

        do_reset();
        #1;
        chk("rst_pos", int'(bus.pos), INIT_POS);
        chk("rst_moving", int'(bus.moving), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_at_min", int'(bus.at_min), 0);
        chk("rst_at_max", int'(bus.at_max), 0);

        // Single step after reset
        cyc(0, 1, 0, 0); settle();
        chk("step_moving_hi", int'(bus.moving), 1);
        cyc(0, 0, 1, 0); settle();
        chk("step_pos", int'(bus.pos), 204);
        chk("step_moving_lo", int'(bus.moving), 0);

        // Queue saturation on the negative side
        do_reset();
        ovf_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 0, 0);
            @(posedge clk); #2;
            ovf_cnt += int'(bus.overflow);
        end
        chk("sat_overflow_pulses", ovf_cnt, 2);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
        settle();
        chk("sat_pos_after7", int'(bus.pos), 172);
        chk("sat_moving_after7", int'(bus.moving), 0);
        cyc(0, 0, 1, 0); settle();
        chk("sat_pos_after8", int'(bus.pos), 172);

        // Limit flush at the top of the playfield
        do_reset();
        for (int i = 0; i < 50; i++) cyc(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        settle();
        chk("flush_pre_pos", int'(bus.pos), 396);
        cyc(0, 0, 1, 0); settle();
        chk("flush_pos", int'(bus.pos), 400);
        chk("flush_at_max", int'(bus.at_max), 1);
        chk("flush_moving", int'(bus.moving), 0);
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); settle();
        chk("flush_hold", int'(bus.pos), 400);

        // Simultaneous events
        do_reset();
        cyc(1, 1, 0, 0); settle();
        chk("both_moving", int'(bus.moving), 0);
        chk("both_overflow", int'(bus.overflow), 0);
        cyc(0, 1, 1, 0); settle();
        chk("pulse_tick_pos", int'(bus.pos), 200);
        cyc(0, 0, 1, 0); settle();
        chk("pulse_tick_next", int'(bus.pos), 204);

        // Recenter from the bottom wall with steps still queued
        do_reset();
        for (int i = 0; i < 51; i++) cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        settle();
        chk("rc_pre_pos", int'(bus.pos), 0);
        chk("rc_pre_at_min", int'(bus.at_min), 1);
        cyc(0, 0, 1, 1); settle();
        chk("rc_pos_hold", int'(bus.pos), 0);
        chk("rc_moving", int'(bus.moving), 1);
        for (int i = 0; i < 50; i++) cyc(1, 0, 1, 0);
        settle();
        chk("rc_pos_done", int'(bus.pos), 200);
        chk("rc_idle", int'(bus.moving), 0);
        chk("rc_overflow", int'(bus.overflow), 0);

        // Asynchronous reset in the middle of a move
        do_reset();
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 1, 0);
        settle();
        chk("ar_pre_pos", int'(bus.pos), 204);
        chk("ar_pre_moving", int'(bus.moving), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_pos", int'(bus.pos), 200);
        chk("ar_moving", int'(bus.moving), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Biased random traffic
        for (int seg = 0; seg < 40; seg++) begin
            int bias;
            int pl;
            int pr;
            bias = int'($urandom_range(0, 2));
            pl = (bias == 0) ? 60 : (bias == 1) ? 10 : 30;
            pr = (bias == 1) ? 60 : (bias == 0) ? 10 : 30;
            for (int i = 0; i < 60; i++) begin
                cyc(($urandom % 100) < pl, ($urandom % 100) < pr,
                    ($urandom % 4) == 0, ($urandom % 150) == 0);
            end
        end
        settle();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/paddle_pos_ctrl.md
# paddle_pos_ctrl

Paddle position controller for the pong game. It sits directly downstream of the dip-switch direction decoder and consumes its single-cycle `left_op` / `right_op` step pulses. It queues the requested steps and applies one step per frame tick, clamped to the playfield. It supplies the registered paddle position to the renderer and to collision logic, and supports a gradual return-to-centre on a game-level request.

## Interface
- `POS_W`, 10: width of the position register.
- `POS_MAX`, 400: highest legal position (screen height minus paddle height); lowest is 0.
- `STEP`, 4: pixels moved per applied step; 1 ≤ STEP ≤ POS_MAX.
- `PEND_MAX`, 7: magnitude limit of the pending-step queue; 1 ≤ PEND_MAX ≤ 7.
- `INIT_POS`, 200: reset and recenter target; 0 ≤ INIT_POS ≤ POS_MAX.
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `left_op`, input, 1: one-cycle pulse requesting one step toward 0.
- `right_op`, input, 1: one-cycle pulse requesting one step toward POS_MAX.
- `frame_tick`, input, 1: one-cycle pulse per video frame; moves are applied only on this pulse.
- `recenter`, input, 1: one-cycle pulse that starts a return to INIT_POS.
- `pos`, output, POS_W: registered paddle position.
- `moving`, output, 1: high when the state is not IDLE.
- `at_min`, output, 1: high when pos == 0 (decoded from the registered pos).
- `at_max`, output, 1: high when pos == POS_MAX (decoded from the registered pos).
- `overflow`, output, 1: registered one-cycle pulse, high when a request was dropped because the queue saturated.

## Operation
- Internal state:
  - `pend`: signed 4-bit queue, range −PEND_MAX..+PEND_MAX. Positive means steps toward POS_MAX are queued.
  - `state`: one of IDLE, MOVING, CENTER.
- Per-cycle request delta: `right_op` − `left_op`. Both high in the same cycle gives delta 0 and does not set `overflow`.
- Queue update in IDLE or MOVING:
  - Start from `pend`.
  - If `frame_tick` is high and `pend` ≠ 0, remove one step of magnitude toward 0.
  - Then add delta and saturate to ±PEND_MAX.
  - `overflow` goes high next cycle if the sum before saturation exceeded PEND_MAX in magnitude.
- Position update in IDLE or MOVING:
  - On `frame_tick` with `pend` > 0: pos = min(pos + STEP, POS_MAX).
  - On `frame_tick` with `pend` < 0: pos = max(pos − STEP, 0), with no unsigned underflow.
  - Compute the sum at POS_W+1 bits.
- Limit flush: if an applied step lands on 0 or POS_MAX, the remaining queued steps are discarded. The new `pend` equals the saturated current-cycle delta alone.
- A queued step while already at the limit in its direction is consumed with no movement and then flushed.
- State transitions:
  - IDLE → MOVING when the next `pend` ≠ 0.
  - MOVING → IDLE when the next `pend` == 0.
  - Any state → CENTER on `recenter`. This has priority over `frame_tick` and delta in the same cycle; `pend` is cleared and that cycle's tick is not applied.
- CENTER behaviour:
  - `left_op` and `right_op` are ignored and cause no overflow.
  - On each `frame_tick`, pos moves STEP toward INIT_POS and snaps to INIT_POS when within STEP.
  - When the updated pos equals INIT_POS, the state goes to IDLE.
  - `recenter` during CENTER has no further effect.
  - `recenter` while pos already equals INIT_POS enters CENTER, then returns to IDLE on the next `frame_tick`.

## Timing
- Reset values: pos = INIT_POS, `pend` = 0, state IDLE, `moving` = 0, `overflow` = 0, `at_min` = (INIT_POS == 0), `at_max` = (INIT_POS == POS_MAX).
- `rst_n` low mid-move aborts immediately and asynchronously; there is no completion of queued steps.
- Latency:
  - A pulse sampled at edge n makes `moving` high after edge n.
  - The earliest position change is at the edge where the next `frame_tick` is sampled (≥ n+1); pos is visible on the following cycle.
- A pulse and `frame_tick` in the same cycle: the tick consumes the old `pend` first, so a pulse arriving into an empty queue moves pos one tick later.
- At most one STEP is applied per `frame_tick`. Pulses between ticks accumulate.
- `at_min` and `at_max` change in the same cycle as pos.

## Test plan
- **Single step after reset:** one `right_op` pulse, then `frame_tick` → pos 200→204, `moving` 1→0 after the tick, `pend` = 0.
- **Saturation:** 9 `left_op` pulses with no tick → `pend` = −7, `overflow` pulses exactly twice; 7 ticks → pos = 172; 8th tick → no change.
- **Limit flush:** preload pos = 396 via steps, queue +5, one tick → pos = 400, `at_max` = 1, `pend` = 0, state IDLE; further ticks → no change.
- **Simultaneous events:**
  - `left_op` and `right_op` together → no queue change, no overflow.
  - `right_op` with `frame_tick` on an empty queue → no move this tick, +4 on the next tick.
- **Recenter:**
  - From pos = 0 with `pend` = −3, pulse `recenter` together with `frame_tick` → `pend` = 0, pos stays 0 that cycle.
  - Then 50 ticks → pos = 200, IDLE; `left_op` pulses during CENTER are ignored.
- **Async reset mid-move:** assert `rst_n` low between ticks while MOVING → pos = 200, `moving` = 0 immediately, without waiting for a `clk` edge.
